// File: rtl/hs_rx_pkg.sv
// Shared types and default constants for the 4-phase handshake receiver.
// No logic; imported by the responder, its interface and the bench.
package hs_rx_pkg;

  localparam int DEF_DATA_W         = 8;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int XFER_CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/hs_rx_responder_if.sv
// Sender/consumer-facing signal bundle of the handshake receiver.
// slave = responder side, master = sender plus downstream consumer.
interface hs_rx_responder_if
  import hs_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic                  req_in;
  logic [DATA_W-1:0]     data_in;
  logic                  ack_out;
  logic [DATA_W-1:0]     data_out;
  logic                  valid_out;
  logic                  ready_in;
  logic [XFER_CNT_W-1:0] xfer_count;
  logic                  timeout_err;

  modport slave (
    input  req_in, data_in, ready_in,
    output ack_out, data_out, valid_out, xfer_count, timeout_err
  );

  modport master (
    output req_in, data_in, ready_in,
    input  ack_out, data_out, valid_out, xfer_count, timeout_err
  );

endinterface

// File: rtl/bit_sync.sv
// N-stage single-bit synchronizer with synchronous active-low reset.
// Latency STAGES cycles; no backpressure.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hs_rx_responder.sv
// 4-phase req/ack receiver: req_in -> SYNC_STAGES+1 cycles -> valid_out; ack_out raised only after consumer handshake.
// Backpressure: word held in HOLD until ready_in; optional ACK watchdog under HS_RX_TIMEOUT_EN.
module hs_rx_responder
  import hs_rx_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic               dst_clock,
  input logic               dst_reset_n,
  hs_rx_responder_if.slave  bus
);

  state_e                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [XFER_CNT_W-1:0] xfer_count_q, xfer_count_d;
  logic                  req_sync;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk_i  (dst_clock),
    .rst_ni (dst_reset_n),
    .d_i    (bus.req_in),
    .q_o    (req_sync)
  );

  always_ff @(posedge dst_clock) begin
    if (!dst_reset_n) begin
      state_q      <= IDLE;
      ack_q        <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  // data_in is only sampled once req_sync proves the sender has settled it.
  always_comb begin
    state_d      = state_q;
    ack_d        = ack_q;
    valid_d      = valid_q;
    data_d       = data_q;
    xfer_count_d = xfer_count_q;
    unique case (state_q)
      IDLE: begin
        if (req_sync) begin
          data_d  = bus.data_in;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && bus.ready_in) begin
          valid_d      = 1'b0;
          ack_d        = 1'b1;
          xfer_count_d = xfer_count_q + 1'b1;
          state_d      = ACK;
        end
      end
      ACK: begin
        if (!req_sync) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef HS_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;
  logic            enter_ack;

  assign enter_ack = (state_q == HOLD) && (state_d == ACK);

  // Counter saturates at the limit; the error is sticky and never touches the FSM.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_err_d = to_err_q;
    if (enter_ack) begin
      to_cnt_d = '0;
    end else if (state_q == ACK) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        to_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge dst_clock) begin
    if (!dst_reset_n) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign bus.timeout_err = to_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign bus.timeout_err    = 1'b0;
`endif

  assign bus.ack_out    = ack_q;
  assign bus.valid_out  = valid_q;
  assign bus.data_out   = data_q;
  assign bus.xfer_count = xfer_count_q;

endmodule

// File: tb/tb_hs_rx_responder.sv
// Self-checking bench for hs_rx_responder: vector table of transfers plus reset, wrap and timeout sequences.
// Captured words are scoreboarded against the consumer handshakes seen on the output.
module tb_hs_rx_responder;
  import hs_rx_pkg::*;

  localparam int TB_TIMEOUT = 16;
  localparam int WAIT_MAX   = 40;

  typedef struct {
    logic [7:0] data;
    int         rwait;
    int         hold;
    int         exp_lat;
    int         exp_drop;
  } vec_t;

  logic       clk;
  logic       rst_n;
  int         errors;
  int         checks;
  logic [15:0] exp_cnt;
  logic [7:0] sb_q[$];
  logic [7:0] mon_exp;
  vec_t       vecs[5];

  hs_rx_responder_if #(.DATA_W(8)) bus ();

  hs_rx_responder #(
    .DATA_W         (8),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .dst_clock   (clk),
    .dst_reset_n (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consumer-side monitor: each accepted word must match the oldest request.
  always @(negedge clk) begin
    if (rst_n && bus.valid_out && bus.ready_in) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got 0x%0h expected no word at %0t", bus.data_out, $time);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("sb_data", {24'd0, bus.data_out}, {24'd0, mon_exp});
      end
    end
  end

  task automatic send_and_accept(input logic [7:0] d, input int rwait, input int exp_lat);
    int n;
    bit stable;
    bus.req_in   = 1'b1;
    bus.data_in  = d;
    bus.ready_in = (rwait == 0);
    sb_q.push_back(d);
    n = 0;
    while (!bus.valid_out && n < WAIT_MAX) begin
      step();
      n++;
    end
    chk("cap_latency", n, exp_lat);
    chk("cap_data", {24'd0, bus.data_out}, {24'd0, d});
    stable = 1'b1;
    for (int k = 0; k < rwait; k++) begin
      if (!bus.valid_out || bus.data_out !== d || bus.ack_out) stable = 1'b0;
      step();
    end
    if (rwait > 0) chk("hold_stable", {31'd0, stable}, 32'd1);
    bus.ready_in = 1'b1;
    step();
    exp_cnt = exp_cnt + 16'd1;
    chk("ack_rise", {31'd0, bus.ack_out}, 32'd1);
    chk("valid_clear", {31'd0, bus.valid_out}, 32'd0);
    chk("xfer_count", {16'd0, bus.xfer_count}, {16'd0, exp_cnt});
    bus.ready_in = 1'b0;
  endtask

  task automatic release_req(input int hold, input int exp_drop);
    int n;
    bit bad;
    bad = 1'b0;
    for (int k = 0; k < hold; k++) begin
      step();
      if (bus.valid_out || !bus.ack_out) bad = 1'b1;
    end
    if (hold > 0) chk("persist_one_word", {31'd0, bad}, 32'd0);
    bus.req_in = 1'b0;
    n = 0;
    while (bus.ack_out && n < WAIT_MAX) begin
      step();
      n++;
    end
    chk("ack_drop_latency", n, exp_drop);
  endtask

  initial begin
    int n;
    logic exp_to;
    errors  = 0;
    checks  = 0;
    exp_cnt = 16'd0;

    vecs[0] = '{data: 8'hA5, rwait: 0,  hold: 0,  exp_lat: 3, exp_drop: 3};
    vecs[1] = '{data: 8'h3C, rwait: 10, hold: 0,  exp_lat: 3, exp_drop: 3};
    vecs[2] = '{data: 8'h5A, rwait: 0,  hold: 50, exp_lat: 3, exp_drop: 3};
    vecs[3] = '{data: 8'hFF, rwait: 2,  hold: 0,  exp_lat: 3, exp_drop: 3};
    vecs[4] = '{data: 8'h00, rwait: 1,  hold: 3,  exp_lat: 3, exp_drop: 3};

    rst_n        = 1'b0;
    bus.req_in   = 1'b0;
    bus.data_in  = 8'h00;
    bus.ready_in = 1'b0;
    repeat (3) step();
    chk("rst_ack", {31'd0, bus.ack_out}, 32'd0);
    chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("rst_data", {24'd0, bus.data_out}, 32'd0);
    chk("rst_count", {16'd0, bus.xfer_count}, 32'd0);
    chk("rst_timeout", {31'd0, bus.timeout_err}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      send_and_accept(vecs[i].data, vecs[i].rwait, vecs[i].exp_lat);
      release_req(vecs[i].hold, vecs[i].exp_drop);
    end

    // Reset while a word waits in HOLD: word dropped, fresh capture afterwards.
    bus.req_in   = 1'b1;
    bus.data_in  = 8'h3C;
    bus.ready_in = 1'b0;
    sb_q.push_back(8'h3C);
    n = 0;
    while (!bus.valid_out && n < WAIT_MAX) begin
      step();
      n++;
    end
    chk("hold_reach", n, 3);
    rst_n = 1'b0;
    step();
    chk("mid_rst_ack", {31'd0, bus.ack_out}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("mid_rst_data", {24'd0, bus.data_out}, 32'd0);
    chk("mid_rst_count", {16'd0, bus.xfer_count}, 32'd0);
    chk("mid_rst_timeout", {31'd0, bus.timeout_err}, 32'd0);
    sb_q.delete();
    exp_cnt = 16'd0;
    step();
    rst_n = 1'b1;
    send_and_accept(8'h96, 0, 3);
    release_req(0, 3);

    // Counter wrap: preload to 0xFFFF, one more transfer must give zero.
    dut.xfer_count_q = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    step();
    send_and_accept(8'hC3, 0, 3);
    chk("wrap_zero", {16'd0, bus.xfer_count}, 32'd0);
    release_req(0, 3);

    // Request never drops: watchdog fires after TB_TIMEOUT cycles in ACK.
`ifdef HS_RX_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    send_and_accept(8'h77, 0, 3);
    repeat (TB_TIMEOUT - 1) step();
    chk("timeout_early", {31'd0, bus.timeout_err}, 32'd0);
    step();
    chk("timeout_set", {31'd0, bus.timeout_err}, {31'd0, exp_to});
    repeat (10) step();
    chk("timeout_sticky", {31'd0, bus.timeout_err}, {31'd0, exp_to});
    chk("timeout_ack_held", {31'd0, bus.ack_out}, 32'd1);
    release_req(0, 3);
    chk("timeout_after_idle", {31'd0, bus.timeout_err}, {31'd0, exp_to});

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
